// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: holds the PC, reads the combinational instruction
// memory and buffers {pc, byte} pairs in a small FIFO for decode (valid/ready).
module imem_fetch_unit #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MEM_DEPTH  = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] Read_Address,
    input  logic [7:0]        instruction,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [7:0]        instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_fault
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < MEM_DEPTH;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_pc_q    [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_pc_d    [FIFO_DEPTH];
    logic [7:0]        mem_instr_q [FIFO_DEPTH];
    logic [7:0]        mem_instr_d [FIFO_DEPTH];

    logic              pop_c;
    logic              push_c;
    logic [ADDR_W-1:0] pc_inc_c;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_c    = valid_q & instr_ready;
    assign pc_inc_c = pc_q + ADDR_W'(1);
    assign push_c   = (state_q == S_FETCH) && enable && !redirect_valid
                      && ((count_q < FULL_CNT) || pop_c) && in_range(pc_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (!enable)                         state_d = S_IDLE;
            else if (in_range(redirect_target))  state_d = S_FETCH;
            else                                 state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) state_d = in_range(pc_q) ? S_FETCH : S_FAULT;
                end
                S_FETCH: begin
                    if (!enable)               state_d = S_IDLE;
                    else if (push_c)           state_d = in_range(pc_inc_c) ? S_FETCH : S_FAULT;
                    else if (!in_range(pc_q))  state_d = S_FAULT;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // PC and FIFO bookkeeping; a redirect flushes whatever was not handed over this cycle.
    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;
        if (redirect_valid) begin
            pc_d    = redirect_target;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                mem_pc_d[tail_q]    = pc_q;
                mem_instr_d[tail_q] = instruction;
                tail_d              = ptr_inc(tail_q);
                pc_d                = pc_inc_c;
            end
            if (pop_c) begin
                head_d = ptr_inc(head_q);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        valid_d = (count_d != '0);
        fault_d = !redirect_valid && (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
        end
    end

    assign Read_Address = pc_q;
    assign instr_out    = mem_instr_q[head_q];
    assign pc_out       = mem_pc_q[head_q];
    assign instr_valid  = valid_q;
    assign fetch_fault  = fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed vector table plus a randomized-backpressure ordering run for imem_fetch_unit.
module tb_imem_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Read_Address;
    logic [7:0] instruction;
    logic       enable;
    logic       redirect_valid;
    logic [7:0] redirect_target;
    logic [7:0] instr_out;
    logic [7:0] pc_out;
    logic       instr_valid;
    logic       instr_ready;
    logic       fetch_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: words 0..4 are 0x61, the rest a simple pattern.
    function automatic logic [7:0] mem_word(input logic [7:0] a);
        return (a < 8'd5) ? 8'h61 : 8'(a * 8'd7 + 8'd1);
    endfunction

    assign instruction = mem_word(Read_Address);

    imem_fetch_unit #(.ADDR_W(8), .MEM_DEPTH(32), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .Read_Address    (Read_Address),
        .instruction     (instruction),
        .enable          (enable),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .fetch_fault     (fetch_fault)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       rdy;
        logic       rv;
        logic [7:0] tgt;
        logic       ev;
        logic       cd;
        logic [7:0] epc;
        logic [7:0] ei;
        logic [7:0] era;
        logic       ef;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic rdy, input logic rv,
                       input logic [7:0] tgt, input logic ev, input logic cd,
                       input logic [7:0] epc, input logic [7:0] ei,
                       input logic [7:0] era, input logic ef);
        vec_t v;
        v = '{rst, en, rdy, rv, tgt, ev, cd, epc, ei, era, ef};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int delivered;
        int cycles;

        reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0;
        redirect_target = 8'h00; instr_ready = 1'b0;

        //  rst en rdy rv tgt    ev cd epc    ei     era    ef
        // Streaming
        add(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h01, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h61, 8'h02, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h02, 8'h61, 8'h03, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h03, 8'h61, 8'h04, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h04, 8'h61, 8'h05, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h05, 8'h24, 8'h06, 0);
        // Backpressure
        add(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h01, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h02, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h02, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h02, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h02, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h02, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h61, 8'h03, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h02, 8'h61, 8'h04, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h03, 8'h61, 8'h05, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h04, 8'h61, 8'h06, 0);
        // Redirect while streaming
        add(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h01, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h61, 8'h02, 0);
        add(0, 1, 1, 1, 8'h03, 0, 0, 8'h00, 8'h00, 8'h03, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h03, 8'h61, 8'h04, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h04, 8'h61, 8'h05, 0);
        // Fault at the end of populated memory, then recovery
        add(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 1, 8'h1E, 0, 0, 8'h00, 8'h00, 8'h1E, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h1E, 8'hD3, 8'h1F, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h1F, 8'hDA, 8'h20, 1);
        add(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h20, 1);
        add(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h20, 1);
        add(0, 1, 1, 1, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h01, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h61, 8'h02, 0);
        // Enable gating
        add(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h01, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h61, 8'h02, 0);
        add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h02, 0);
        add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h02, 0);
        add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h02, 0);
        add(0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h02, 0);
        add(0, 1, 1, 0, 8'h00, 1, 1, 8'h02, 8'h61, 8'h03, 0);
        // Reset with a full FIFO and a simultaneous redirect
        add(1, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h01, 0);
        add(0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h61, 8'h02, 0);
        add(1, 1, 1, 1, 8'h05, 0, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset           = vecs[i].rst;
            enable          = vecs[i].en;
            instr_ready     = vecs[i].rdy;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
            chk($sformatf("row%0d_raddr", i), 32'(Read_Address), 32'(vecs[i].era));
            chk($sformatf("row%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].ef));
            if (vecs[i].cd) begin
                chk($sformatf("row%0d_pc_out", i), 32'(pc_out), 32'(vecs[i].epc));
                chk($sformatf("row%0d_instr_out", i), 32'(instr_out), 32'(vecs[i].ei));
            end
        end

        // Full run to the fault with random backpressure: every word 0..31 exactly once, in order.
        reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; enable = 1'b1;
        delivered = 0;
        cycles    = 0;
        while (delivered < 32 && cycles < 400) begin
            instr_ready = 1'($urandom_range(0, 1));
            #1;
            if (instr_valid && instr_ready) begin
                chk($sformatf("stream_pc%0d", delivered), 32'(pc_out), 32'(delivered));
                chk($sformatf("stream_instr%0d", delivered), 32'(instr_out),
                    32'(mem_word(8'(delivered))));
                delivered++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        chk("stream_delivered_count", 32'(delivered), 32'd32);
        instr_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("stream_end_fault", 32'(fetch_fault), 32'd1);
        chk("stream_end_valid", 32'(instr_valid), 32'd0);
        chk("stream_end_raddr", 32'(Read_Address), 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Instruction fetch front end that drives the instruction memory's `Read_Address` and captures the returned `instruction` byte, with the program counter held internally. Each fetched byte and its PC go into a small FIFO and are handed to decode over a valid/ready handshake. Execute can redirect fetch (jump/branch) to flush and restart. It sits between the combinational instruction memory and the decode stage of the 8-bit core.

## Interface

Parameters
- `ADDR_W`, 8: PC / `Read_Address` width.
- `MEM_DEPTH`, 32: number of populated instruction words; PC ≥ MEM_DEPTH is a fetch fault.
- `FIFO_DEPTH`, 2: fetch buffer entries (2..4).

Ports
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `Read_Address`, out, ADDR_W: to instruction memory; equals PC register.
- `instruction`, in, 8: from instruction memory, combinational on `Read_Address`, same cycle.
- `enable`, in, 1: fetch permitted when high.
- `redirect_valid`, in, 1: one-cycle pulse from execute, flush and jump.
- `redirect_target`, in, ADDR_W: new PC, sampled when `redirect_valid`.
- `instr_out`, out, 8: FIFO head instruction.
- `pc_out`, out, ADDR_W: PC of FIFO head.
- `instr_valid`, out, 1: FIFO non-empty.
- `instr_ready`, in, 1: decode accepts head.
- `fetch_fault`, out, 1: PC out of range; sticky.

## Operation

- State machine: IDLE, FETCH, FAULT.
  - IDLE: no fetch. Go to FETCH when `enable`=1 and PC < MEM_DEPTH. Go to FAULT when `enable`=1 and PC ≥ MEM_DEPTH.
  - FETCH: each cycle, push {PC, `instruction`} when push is allowed, then PC ← PC+1 modulo 2^ADDR_W. Go to IDLE when `enable`=0; no push that cycle, PC held.
  - FAULT: `fetch_fault`=1, no pushes, PC held. Leave only on reset or redirect.
  - The FETCH→FAULT check runs every cycle: if the PC after an increment is ≥ MEM_DEPTH, the next state is FAULT. The byte at MEM_DEPTH-1 is still pushed.
- Push allowed: count < FIFO_DEPTH, or count = FIFO_DEPTH with a pop in the same cycle. Full-rate throughput is one instruction per cycle.
- Pop: `instr_valid` & `instr_ready`. Head advances; count decrements unless a push occurs in the same cycle.
- Redirect (highest priority after reset):
  - A handshake completing in the redirect cycle counts as delivered. All other FIFO entries are discarded and count ← 0.
  - PC ← `redirect_target`. No push in that cycle.
  - `fetch_fault` ← 0. Next state is FETCH if `enable`=1 and target < MEM_DEPTH, FAULT if `enable`=1 and target ≥ MEM_DEPTH, otherwise IDLE.
- `enable` low does not block pops; the FIFO drains normally.
- PC arithmetic is unsigned ADDR_W bits; 0xFF+1 wraps to 0x00. With default MEM_DEPTH the fault triggers before any wrap.

## Timing

- Reset values: PC=0, `Read_Address`=0x00, count=0, `instr_valid`=0, `instr_out`=0x00, `pc_out`=0x00, `fetch_fault`=0, state=IDLE.
- Reset asserted mid-stream clears everything on that edge. Redirect or handshake in the same cycle is ignored.
- Latency: `instruction` is sampled on the edge where PC=N is pushed. `instr_valid` is high with `pc_out`=N from the next cycle. Reset-release to first valid takes 2 cycles with `enable` high: one cycle IDLE→FETCH, one cycle to push.
- Redirect: the target's instruction appears at `instr_out` 2 cycles after the `redirect_valid` edge. `instr_valid` is 0 in the cycle immediately after the redirect.
- `instr_out`, `pc_out`, `instr_valid` and `fetch_fault` are registered or FIFO-direct; none depends combinationally on `instr_ready`. The push-allowed term may depend on `instr_ready`.
- Held entries remain stable while `instr_valid`=1 and `instr_ready`=0.

## Test plan

- Streaming: reset, `enable`=1, `instr_ready`=1, memory words 0..4 = 0x61. Expect `pc_out` 0,1,2,3,4 on consecutive cycles, `instr_out`=0x61 each, no bubbles after first valid.
- Backpressure: `instr_ready`=0 for 5 cycles after first valid. Expect count=2, `pc_out` held at 0, PC frozen at 2. Release `instr_ready`: `pc_out` 0,1,2,3 with no loss or duplication.
- Redirect: while streaming, pulse `redirect_valid` with `redirect_target`=0x03 when `pc_out`=1 is accepted. Expect no delivery of pc 2. Next valid has `pc_out`=3 two cycles later.
- Fault: redirect to 0x1E, MEM_DEPTH=32. Expect `pc_out` 0x1E, 0x1F delivered, then `fetch_fault`=1, `Read_Address` stuck at 0x20, no more valids. Redirect to 0x00 clears the fault and resumes.
- Enable gating: drop `enable` for 3 cycles mid-stream. The FIFO drains and PC is held. Raising `enable` resumes from the held PC, with the first new valid 2 cycles later.
- Mid-operation reset: assert `reset` with FIFO full and a redirect in the same cycle. Expect all reset values next cycle and PC=0, not the redirect target.
